syspll_seq: RTL and testbench
=============================

// Module: syspll_seq
// PURPOSE
//  Reset/lock sequencer for the system PLL and its glitch-free clock mux. Runs on the
//  free-running fabric clock. Pulses the PLL reset, waits for lock with a timeout,
//  qualifies lock for a stable interval, then selects the PLL clock. Recovers from
//  lock loss by falling back to the fabric clock and re-sequencing; escalates to FAULT.
// PARAMETERS
//  RST_CYCLES   16       cycles pll_rst_n held low per reset attempt (>=1)
//  LOCK_TIMEOUT 1048576  cycles in WAIT_LOCK before attempt counts as failed (>=2)
//  LOCK_STABLE  1024     consecutive synced-lock cycles required before RUN (>=1)
//  MAX_RETRY    7        failed attempts before FAULT (1..15)
// PORTS
//  clk         in   1   fabric clock (free-running), sole clock
//  rst         in   1   synchronous, active-high reset
//  enable      in   1   level; 0 forces IDLE from any state (highest priority after rst)
//  restart     in   1   1-cycle pulse; re-sequence from RESET, clears retry_cnt
//  pll_locked  in   1   PLL lock, asynchronous; 2-flop synchronised internally -> lock_s
//  pll_rst_n   out  1   PLL reset, active low, registered
//  clk_sel     out  1   clock mux select: 0 fabric clock, 1 PLL clock; registered
//  ready       out  1   1 only in RUN
//  fault       out  1   1 only in FAULT
//  state       out  3   IDLE=0 RESET=1 WAIT_LOCK=2 QUALIFY=3 RUN=4 FAULT=5
//  retry_cnt   out  4   failed attempts since last RUN/restart
//  unlock_cnt  out  16  lock losses seen in RUN, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: state=IDLE, pll_rst_n=0, clk_sel=0, ready=0, fault=0, counters=0, sync flops=0.
//  All outputs registered; each is a function of state (Moore): pll_rst_n=0 in IDLE/RESET/FAULT,
//   1 otherwise; clk_sel=ready=(state==RUN); fault=(state==FAULT).
//  Priority per cycle: rst > !enable > restart > state transition.
//  IDLE: enable=1 -> RESET (cnt=0).
//  RESET: cnt counts 0..RST_CYCLES-1; at RST_CYCLES-1 -> WAIT_LOCK, cnt=0.
//   pll_rst_n low for exactly RST_CYCLES cycles.
//  WAIT_LOCK: lock_s=1 -> QUALIFY, cnt=0. Else cnt==LOCK_TIMEOUT-1 -> failure.
//  QUALIFY: lock_s=0 -> failure. cnt==LOCK_STABLE-1 with lock_s=1 -> RUN, retry_cnt=0.
//  Failure: retry_cnt+1; if new value >= MAX_RETRY -> FAULT, else -> RESET, cnt=0.
//  RUN: lock_s=0 -> unlock_cnt+1 (sat), -> RESET; clk_sel falls next cycle (mux itself
//   switches glitch-free). retry_cnt unchanged on this transition.
//  FAULT: absorbing; PLL held in reset; exits only via restart (-> RESET, retry_cnt=0),
//   !enable (-> IDLE, retry_cnt kept) or rst.
//  restart in IDLE ignored. restart in any other state -> RESET, cnt=0, retry_cnt=0;
//   unlock_cnt never cleared except by rst.
//  !enable: -> IDLE, pll_rst_n low next cycle; counters kept.
//  Latency: pll_locked rise -> lock_s 2 cycles -> QUALIFY 1 cycle later.
//  Minimum enable->ready: RST_CYCLES + 2 + 1 + LOCK_STABLE cycles.
//  Single shared cnt, width clog2(max(RST_CYCLES,LOCK_TIMEOUT,LOCK_STABLE)); no wrap
//   (always cleared on state entry).
// TESTING (use RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, MAX_RETRY=3)
//  rst then enable=1, pll_locked=1 at WAIT_LOCK entry -> pll_rst_n low 4 cycles,
//   ready/clk_sel=1 exactly 4+3+8 cycles after enable, retry_cnt=0.
//  pll_locked stuck 0 -> 3 timeouts of 32 cycles, 3 reset pulses, then FAULT, fault=1,
//   retry_cnt=3, pll_rst_n=0; restart pulse -> RESET, retry_cnt=0.
//  In RUN drop pll_locked for 1 cycle -> clk_sel=0 within 3 cycles, unlock_cnt=1,
//   new 4-cycle reset pulse, relock returns to RUN.
//  Lock glitch in QUALIFY (drop at cnt=5) -> retry_cnt=1, back to RESET, no RUN entry.
//  enable=0 mid-WAIT_LOCK and simultaneous restart -> IDLE next cycle (enable wins),
//   pll_rst_n=0; rst asserted in RUN -> all outputs at reset values next cycle.
//  Force unlock_cnt to 16'hFFFF, lose lock again -> stays 16'hFFFF.

Source files
------------

// File: rtl/syspll_seq.sv
// Reset/lock sequencer for the system PLL: pulses PLL reset, waits for lock with timeout,
// qualifies lock stability, then selects the PLL clock; falls back and retries on loss.
module syspll_seq #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 1048576,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRY    = 7
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_restart,
  input  logic        i_pll_locked,
  output logic        o_pll_rst_n,
  output logic        o_clk_sel,
  output logic        o_ready,
  output logic        o_fault,
  output logic [2:0]  o_state,
  output logic [3:0]  o_retry_cnt,
  output logic [15:0] o_unlock_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RESET = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_QUAL  = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  localparam int MAXV01 = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAXV   = (MAXV01 > LOCK_STABLE) ? MAXV01 : LOCK_STABLE;
  localparam int CW     = (MAXV > 1) ? $clog2(MAXV) : 1;

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STAB_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_retry_cnt;
  logic [15:0]   r_unlock_cnt;
  logic          r_lock_meta;
  logic          r_lock_s;
  logic          r_pll_rst_n;
  logic          r_clk_sel;
  logic          r_ready;
  logic          r_fault;

  logic [2:0]    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [3:0]    w_retry_nxt;
  logic [15:0]   w_unlock_nxt;
  logic          w_fail;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_retry_nxt  = r_retry_cnt;
    w_unlock_nxt = r_unlock_cnt;
    w_fail       = 1'b0;
    if (!i_enable) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else if (i_restart && (r_state != S_IDLE)) begin
      w_state_nxt = S_RESET;
      w_cnt_nxt   = '0;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_RESET;
          w_cnt_nxt   = '0;
        end
        S_RESET: begin
          if (r_cnt == RST_LAST) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (r_lock_s) begin
            w_state_nxt = S_QUAL;
            w_cnt_nxt   = '0;
          end else if (r_cnt == TO_LAST) begin
            w_fail = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_QUAL: begin
          if (!r_lock_s) begin
            w_fail = 1'b1;
          end else if (r_cnt == STAB_LAST) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
            w_retry_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_RUN: begin
          // Lock loss does not count as a failed attempt; only the unlock tally moves.
          if (!r_lock_s) begin
            w_state_nxt  = S_RESET;
            w_cnt_nxt    = '0;
            w_unlock_nxt = (r_unlock_cnt == 16'hFFFF) ? r_unlock_cnt : r_unlock_cnt + 16'd1;
          end
        end
        S_FAULT: ;
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
      if (w_fail) begin
        w_retry_nxt = r_retry_cnt + 4'd1;
        w_state_nxt = (w_retry_nxt >= RETRY_MAX) ? S_FAULT : S_RESET;
        w_cnt_nxt   = '0;
      end
    end
  end

  // Outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_retry_cnt  <= '0;
      r_unlock_cnt <= '0;
      r_lock_meta  <= 1'b0;
      r_lock_s     <= 1'b0;
      r_pll_rst_n  <= 1'b0;
      r_clk_sel    <= 1'b0;
      r_ready      <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_retry_cnt  <= w_retry_nxt;
      r_unlock_cnt <= w_unlock_nxt;
      r_lock_meta  <= i_pll_locked;
      r_lock_s     <= r_lock_meta;
      r_pll_rst_n  <= !((w_state_nxt == S_IDLE) || (w_state_nxt == S_RESET) ||
                        (w_state_nxt == S_FAULT));
      r_clk_sel    <= (w_state_nxt == S_RUN);
      r_ready      <= (w_state_nxt == S_RUN);
      r_fault      <= (w_state_nxt == S_FAULT);
    end
  end

  assign o_pll_rst_n  = r_pll_rst_n;
  assign o_clk_sel    = r_clk_sel;
  assign o_ready      = r_ready;
  assign o_fault      = r_fault;
  assign o_state      = r_state;
  assign o_retry_cnt  = r_retry_cnt;
  assign o_unlock_cnt = r_unlock_cnt;

endmodule

// File: tb/tb_syspll_seq.sv
// Bench for syspll_seq: directed sequencing scenarios plus random lock/enable/restart
// traffic, all checked every cycle against a dwell-time reference model.
module tb_syspll_seq;
  localparam int RC = 4, TO = 32, LS = 8, MR = 3;

  logic        clk = 1'b0;
  logic        rst, en, rs, lk;
  logic        pll_rst_n, clk_sel, ready, fault;
  logic [2:0]  state;
  logic [3:0]  retry_cnt;
  logic [15:0] unlock_cnt;

  syspll_seq #(.RST_CYCLES(RC), .LOCK_TIMEOUT(TO), .LOCK_STABLE(LS), .MAX_RETRY(MR)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_restart(rs), .i_pll_locked(lk),
    .o_pll_rst_n(pll_rst_n), .o_clk_sel(clk_sel), .o_ready(ready), .o_fault(fault),
    .o_state(state), .o_retry_cnt(retry_cnt), .o_unlock_cnt(unlock_cnt)
  );

  always #5 clk = ~clk;

  int nerr = 0, nchk = 0;
  // Reference model: phase, cycles spent in it, counters, and the lock seen 2 samples ago.
  int ms = 0, dwell = 0, mretry = 0, munlock = 0;
  bit h0 = 1'b0, h1 = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_step();
    bit ls;
    int nx;
    bit reenter;
    ls = h1;
    if (rst) begin
      ms = 0; dwell = 0; mretry = 0; munlock = 0; h0 = 0; h1 = 0;
      return;
    end
    h1 = h0; h0 = lk;
    nx = ms; reenter = 0;
    if (!en) nx = 0;
    else if (rs && ms != 0) begin nx = 1; reenter = 1; mretry = 0; end
    else begin
      case (ms)
        0: nx = 1;
        1: if (dwell + 1 == RC) nx = 2;
        2: if (ls) nx = 3;
           else if (dwell + 1 == TO) begin
             mretry++; nx = (mretry >= MR) ? 5 : 1;
           end
        3: if (!ls) begin
             mretry++; nx = (mretry >= MR) ? 5 : 1;
           end else if (dwell + 1 == LS) begin nx = 4; mretry = 0; end
        4: if (!ls) begin
             nx = 1;
             if (munlock < 65535) munlock++;
           end
        default: nx = 5;
      endcase
    end
    dwell = (nx == ms && !reenter) ? dwell + 1 : 0;
    ms = nx;
  endfunction

  task automatic compare_all();
    chk("state", 32'(state), 32'(ms));
    chk("retry_cnt", 32'(retry_cnt), 32'(mretry));
    chk("unlock_cnt", 32'(unlock_cnt), 32'(munlock));
    chk("pll_rst_n", 32'(pll_rst_n), (ms == 0 || ms == 1 || ms == 5) ? 32'd0 : 32'd1);
    chk("clk_sel", 32'(clk_sel), 32'(ms == 4));
    chk("ready", 32'(ready), 32'(ms == 4));
    chk("fault", 32'(fault), 32'(ms == 5));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic wait_state(input int s, input int lim, input string nm);
    for (int k = 0; k < lim && state != 3'(s); k++) tick();
    chk(nm, 32'(state), 32'(s));
  endtask

  initial begin
    int n, nrst, nres, nwl;
    logic [2:0] prev;
    bit saw_ready;
    rst = 1; en = 0; rs = 0; lk = 0;
    repeat (3) tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pll_rst_n", 32'(pll_rst_n), 32'd0);
    chk("rst_clk_sel", 32'(clk_sel), 32'd0);
    chk("rst_unlock", 32'(unlock_cnt), 32'd0);
    rst = 0;
    tick();

    // Bring-up: lock appears on WAIT_LOCK entry.
    en = 1; n = 0; nrst = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (state == 3'd1 && !pll_rst_n) nrst++;
      if (state == 3'd2) lk = 1;
      if (ready) break;
      n++;
    end
    chk("en_to_ready", 32'(n), 32'd15);
    chk("rst_pulse_len", 32'(nrst), 32'd4);
    chk("run_clk_sel", 32'(clk_sel), 32'd1);
    chk("run_retry", 32'(retry_cnt), 32'd0);

    // One-cycle lock drop in RUN.
    lk = 0; tick(); lk = 1; n = 1;
    for (int k = 0; k < 10 && clk_sel; k++) begin tick(); n++; end
    chk("unlock_fall_lat", 32'(n), 32'd3);
    chk("unlock_cnt1", 32'(unlock_cnt), 32'd1);
    nrst = 0;
    for (int k = 0; k < 200 && !ready; k++) begin
      if (state == 3'd1) nrst++;
      tick();
    end
    chk("relock_rst_len", 32'(nrst), 32'd4);
    chk("relock_ready", 32'(ready), 32'd1);

    // Lock stuck low: three timeouts then FAULT.
    lk = 0; prev = state; nres = 0; nwl = 0;
    for (int k = 0; k < 400 && !fault; k++) begin
      tick();
      if (state == 3'd1 && prev != 3'd1) nres++;
      if (state == 3'd2) nwl++;
      prev = state;
    end
    chk("fault_resets", 32'(nres), 32'd3);
    chk("fault_wait_cycles", 32'(nwl), 32'd96);
    chk("fault_flag", 32'(fault), 32'd1);
    chk("fault_retry", 32'(retry_cnt), 32'd3);
    chk("fault_pll_rst_n", 32'(pll_rst_n), 32'd0);
    repeat (5) tick();
    chk("fault_absorb", 32'(state), 32'd5);
    rs = 1; tick(); rs = 0;
    chk("restart_state", 32'(state), 32'd1);
    chk("restart_retry", 32'(retry_cnt), 32'd0);

    // Lock glitch during QUALIFY.
    lk = 1; saw_ready = 0;
    wait_state(3, 100, "reach_qualify");
    repeat (4) tick();
    lk = 0; tick(); lk = 1;
    saw_ready = saw_ready | ready;
    tick();
    chk("glitch_still_qual", 32'(state), 32'd3);
    tick();
    saw_ready = saw_ready | ready;
    chk("glitch_to_reset", 32'(state), 32'd1);
    chk("glitch_retry", 32'(retry_cnt), 32'd1);
    chk("glitch_no_run", 32'(saw_ready), 32'd0);

    // enable low beats a simultaneous restart.
    lk = 0;
    wait_state(2, 50, "reach_wait");
    tick(); tick();
    en = 0; rs = 1; tick(); rs = 0;
    chk("dis_idle", 32'(state), 32'd0);
    chk("dis_pll_rst_n", 32'(pll_rst_n), 32'd0);
    chk("dis_retry_kept", 32'(retry_cnt), 32'd1);

    // rst while in RUN.
    en = 1; lk = 1;
    wait_state(4, 200, "reach_run2");
    rst = 1; tick(); rst = 0;
    chk("rrun_state", 32'(state), 32'd0);
    chk("rrun_ready", 32'(ready), 32'd0);
    chk("rrun_unlock", 32'(unlock_cnt), 32'd0);

    // unlock_cnt saturation.
    wait_state(4, 200, "reach_run3");
    force dut.r_unlock_cnt = 16'hFFFF;
    munlock = 65535;
    tick();
    release dut.r_unlock_cnt;
    lk = 0; tick(); lk = 1;
    repeat (4) tick();
    chk("sat_unlock", 32'(unlock_cnt), 32'hFFFF);
    chk("sat_state", 32'(state), 32'd1);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      if (en) en = ($urandom_range(0, 299) != 0);
      else    en = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, lk ? 59 : 24) == 0) lk = ~lk;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
